calc_op_sequencer: RTL and testbench
====================================

# calc_op_sequencer

Multi-cycle arithmetic sequencer for the accelerometer calculator: accepts one operation (ADD, SUB, MUL, NEG) on two 17-bit two's-complement operands per start pulse. All arithmetic runs through a single shared instance of the team's 17-bit ripple adder, which this block time-multiplexes. MUL is built from repeated adder passes using shift-add. The block sits between the gesture/keypad decode logic (start, op, operands) and the display formatter (result, ovf, done).

## Interface
- No parameters; width is fixed at 17 by the shared adder.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when busy=0
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 NEG
- a  in  17  operand A, two's complement
- b  in  17  operand B, two's complement; ignored for NEG
- busy  out  1  operation in progress; start ignored while high
- done  out  1  one-cycle pulse; result/ovf valid from this cycle until the next accepted start
- result  out  17  two's-complement result, truncated to 17 bits
- ovf  out  1  true result lies outside [-65536, 65535]

## Operation
- States: IDLE, EXEC, ABS_A, ABS_B, MUL_STEP, SIGN, DONE. busy=1 in every state except IDLE and DONE.
- Acceptance: start=1 while in IDLE or DONE latches op, a, b. Later operand changes are ignored.
- Adder port mux:
  - ADD: a + b, ci=0.
  - SUB: a + ~b, ci=1.
  - NEG: 0 + ~a, ci=1.
  - ABS: 0 + ~x, ci=1 when x[16]=1; otherwise the operand passes through unchanged.
  - MUL_STEP: acc + mc, ci=0.
  - SIGN: 0 + ~acc, ci=1 when the product sign is negative.
- ADD/SUB/NEG: EXEC for one cycle, then DONE.
  - ovf for ADD/SUB uses the signed rule: the adder's effective inputs share a sign and the sum sign differs.
  - ovf for NEG: a = 0x10000.
- MUL:
  - ABS_A sets mc = |a|; ABS_B sets mb = |b|, both as unsigned 17-bit. Product sign is a[16]^b[16]. acc=0.
  - MUL_STEP runs exactly 17 cycles (5-bit step counter). Each cycle:
    - if mb[0], acc = acc + mc;
    - then mc <<= 1 and mb >>= 1.
  - Sticky overflow is set by:
    - an adder carry-out, derived from MSBs: (acc[16]&mc[16]) | ((acc[16]|mc[16]) & ~sum[16]);
    - or mc[16]=1 being shifted out while the shifted mb is nonzero.
  - SIGN negates acc if the product sign is negative.
  - ovf = sticky | (positive & acc[16]) | (negative & acc[16] & acc[15:0]≠0). Magnitude 65536 with negative sign is legal and gives result 0x10000.
  - Zero operand: no sign fix is applied; result=0, ovf=0.
- DONE: done=1 for one cycle, then IDLE. A start in DONE is accepted (back-to-back) and done still deasserts.
- result and ovf update only on the transition into DONE. They hold otherwise.

## Timing
- Reset (async): state=IDLE; busy=0, done=0, result=0, ovf=0; sticky, acc, mc, mb and the counter are cleared. Reset mid-operation aborts with no done pulse.
- start accepted at the edge ending cycle 0 gives:
  - ADD/SUB/NEG: busy in cycle 1, done in cycle 2.
  - MUL: busy in cycles 1–20 (ABS_A, ABS_B, 17×MUL_STEP, SIGN), done in cycle 21. Latency is fixed and independent of data.
- start while busy=1 is dropped; there is no queuing.

## Structure
- Package calc_pkg holds:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_NEG;
  - the state enum;
  - localparams W=17 and MUL_STEPS=17.
- One sub-module: a single instance of the existing 17-bit two's-complement adder, add17bit_2sComp, fed by the operand/ci mux.
- Carry-out is reconstructed from the adder MSBs; the adder itself is not modified.

## Test plan
- ADD a=100, b=-250 (0x1FF06) → result=0x1FF6A (-150), ovf=0, done in cycle 2.
- ADD 65535+1 → result=0x10000, ovf=1. SUB 5-7 → 0x1FFFE, ovf=0. SUB -65536-1 → 0x0FFFF, ovf=1. NEG 0x10000 → ovf=1.
- MUL -300×200 → result=0x115A0 (-60000), ovf=0, done in exactly cycle 21.
- MUL 256×256 → ovf=1. MUL -256×256 → result=0x10000, ovf=0. MUL 0×(-5) → 0, ovf=0.
- start pulsed during MUL cycle 5 with op=ADD → ignored. Back-to-back start in the DONE cycle → accepted, correct second result.
- Assert rst at MUL cycle 10 → busy/result/ovf=0 immediately with no done. A following ADD 3+4 → 7 in cycle 2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operation sequencer: operand width,
// multiply step count, op codes and sequencer states.
package calc_pkg;

  localparam int W         = 17;
  localparam int MUL_STEPS = 17;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    ABS_A,
    ABS_B,
    MUL_STEP,
    SIGN,
    DONE
  } state_e;

endpackage

// File: rtl/add17bit_2sComp.sv
// 17-bit two's-complement ripple adder shared by every calculator operation.
// Only the sum is exported; callers rebuild carry-out from the MSBs.
module add17bit_2sComp
  import calc_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  always_comb begin
    carry    = '0;
    carry[0] = ci;
    for (int i = 1; i < W; i++) begin
      carry[i] = (a[i-1] & b[i-1]) | ((a[i-1] ^ b[i-1]) & carry[i-1]);
    end
    sum = a ^ b ^ carry;
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL/NEG sequencer built around one shared 17-bit adder;
// MUL is unsigned shift-add on operand magnitudes followed by a sign fix.
module calc_op_sequencer
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  state_e       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] acc_q, acc_d, mc_q, mc_d, mb_q, mb_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         sticky_q, sticky_d, neg_q, neg_d;
  logic [W-1:0] result_q, result_d;
  logic         ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

  logic [W-1:0] add_a, add_b, add_sum, mb_shift;
  logic         add_ci, mul_carry;

  add17bit_2sComp u_add (
    .a   (add_a),
    .b   (add_b),
    .ci  (add_ci),
    .sum (add_sum)
  );

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state_q)
      EXEC: begin
        case (op_q)
          OP_ADD:  begin add_a = a_q; add_b = b_q; end
          OP_SUB:  begin add_a = a_q; add_b = ~b_q; add_ci = 1'b1; end
          default: begin add_b = ~a_q; add_ci = 1'b1; end
        endcase
      end
      ABS_A:    begin add_b = ~a_q; add_ci = a_q[W-1]; end
      ABS_B:    begin add_b = ~b_q; add_ci = b_q[W-1]; end
      MUL_STEP: begin add_a = acc_q; add_b = mc_q; end
      SIGN:     begin add_b = ~acc_q; add_ci = neg_q; end
      default:  ;
    endcase
  end

  // Unsigned carry-out of acc + mc, rebuilt from the MSBs because the adder has no cout.
  assign mul_carry = (acc_q[W-1] & mc_q[W-1]) | ((acc_q[W-1] | mc_q[W-1]) & ~add_sum[W-1]);
  assign mb_shift  = mb_q >> 1;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    neg_d    = neg_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = (op == OP_MUL) ? ABS_A : EXEC;
        end
      end
      EXEC: begin
        result_d = add_sum;
        if (op_q == OP_NEG) ovf_d = (a_q == {1'b1, {(W-1){1'b0}}});
        else ovf_d = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
        state_d = DONE;
      end
      ABS_A: begin
        mc_d     = a_q[W-1] ? add_sum : a_q;
        acc_d    = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
        neg_d    = (a_q[W-1] ^ b_q[W-1]) && (a_q != '0) && (b_q != '0);
        state_d  = ABS_B;
      end
      ABS_B: begin
        mb_d    = b_q[W-1] ? add_sum : b_q;
        state_d = MUL_STEP;
      end
      MUL_STEP: begin
        if (mb_q[0]) begin
          acc_d = add_sum;
          if (mul_carry) sticky_d = 1'b1;
        end
        if (mc_q[W-1] && (mb_shift != '0)) sticky_d = 1'b1;
        mc_d  = mc_q << 1;
        mb_d  = mb_shift;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_STEPS - 1)) state_d = SIGN;
      end
      SIGN: begin
        acc_d    = neg_q ? add_sum : acc_q;
        result_d = neg_q ? add_sum : acc_q;
        // A negative magnitude of exactly 2^16 is representable; anything larger is not.
        ovf_d    = sticky_q | (~neg_q & acc_q[W-1]) | (neg_q & acc_q[W-1] & (|acc_q[W-2:0]));
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mb_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mb_q     <= mb_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: an integer-arithmetic reference
// model checked every cycle, plus directed vectors with literal expectations.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [16:0] a = '0;
  logic [16:0] b = '0;
  logic        busy, done, ovf;
  logic [16:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stim_cyc = 0;
  bit chk_en = 1'b0;

  calc_op_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic on true signed integer values.
  function automatic longint sx(input logic [16:0] v);
    return v[16] ? longint'(v) - 64'sd131072 : longint'(v);
  endfunction

  function automatic longint trueVal(input logic [1:0] o, input logic [16:0] x, input logic [16:0] y);
    case (o)
      OP_ADD:  return sx(x) + sx(y);
      OP_SUB:  return sx(x) - sx(y);
      OP_MUL:  return sx(x) * sx(y);
      default: return -sx(x);
    endcase
  endfunction

  function automatic logic [16:0] mRes(input logic [1:0] o, input logic [16:0] x, input logic [16:0] y);
    longint t;
    t = trueVal(o, x, y);
    return t[16:0];
  endfunction

  function automatic logic mOvf(input logic [1:0] o, input logic [16:0] x, input logic [16:0] y);
    longint t;
    t = trueVal(o, x, y);
    return (t < -64'sd65536) || (t > 64'sd65535);
  endfunction

  // Model: cycles since acceptance; done lands at 2 (ADD/SUB/NEG) or 21 (MUL).
  int          m_phase = 0;
  int          m_lat = 2;
  logic [16:0] m_res = '0, p_res = '0;
  logic        m_ovf = 1'b0, p_ovf = 1'b0;
  bit          m_valid = 1'b1, p_valid = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_res   <= '0;
      m_ovf   <= 1'b0;
      m_valid <= 1'b1;
    end else if (start && !(m_phase >= 1 && m_phase < m_lat)) begin
      p_res   <= mRes(op, a, b);
      p_ovf   <= mOvf(op, a, b);
      p_valid <= !(op == OP_MUL && mOvf(op, a, b));
      m_lat   <= (op == OP_MUL) ? 21 : 2;
      m_phase <= 1;
    end else if (m_phase >= 1 && m_phase < m_lat) begin
      m_phase <= m_phase + 1;
      if (m_phase + 1 == m_lat) begin
        m_res   <= p_res;
        m_ovf   <= p_ovf;
        m_valid <= p_valid;
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      checkOutput("busy", 32'(busy), 32'(m_phase >= 1 && m_phase < m_lat));
      checkOutput("done", 32'(done), 32'(m_phase != 0 && m_phase == m_lat));
      checkOutput("ovf", 32'(ovf), 32'(m_ovf));
      if (m_valid) checkOutput("result", 32'(result), 32'(m_res));
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [16:0] x, input logic [16:0] y);
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    stim_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    a     = ~x;
    b     = x ^ y;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc - stim_cyc;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("[TB] FAIL done_timeout: no done within 40 cycles of start at cycle %0d", stim_cyc);
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [16:0] x,
                       input logic [16:0] y, input logic [16:0] er, input logic eo,
                       input int el, input bit checkRes, input int gap);
    int lat;
    repeat (gap) @(negedge clk);
    applyStimulus(o, x, y);
    waitDone(lat);
    checkOutput({name, ".latency"}, 32'(lat), 32'(el));
    if (checkRes) checkOutput({name, ".result"}, 32'(result), 32'(er));
    checkOutput({name, ".ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.result", 32'(result), 32'd0);
    checkOutput("reset.ovf", 32'(ovf), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    runOp("add_100_m250", OP_ADD, 17'd100, 17'h1FF06, 17'h1FF6A, 1'b0, 2, 1, 1);
    runOp("add_max_1", OP_ADD, 17'h0FFFF, 17'd1, 17'h10000, 1'b1, 2, 1, 1);
    runOp("sub_5_7", OP_SUB, 17'd5, 17'd7, 17'h1FFFE, 1'b0, 2, 1, 1);
    runOp("sub_min_1", OP_SUB, 17'h10000, 17'd1, 17'h0FFFF, 1'b1, 2, 1, 1);
    runOp("sub_0_min", OP_SUB, 17'd0, 17'h10000, 17'h10000, 1'b1, 2, 1, 1);
    runOp("neg_min", OP_NEG, 17'h10000, 17'd9, 17'h10000, 1'b1, 2, 1, 1);
    runOp("neg_5", OP_NEG, 17'd5, 17'd0, 17'h1FFFB, 1'b0, 2, 1, 1);

    runOp("mul_m300_200", OP_MUL, 17'h1FED4, 17'd200, 17'h115A0, 1'b0, 21, 1, 1);
    runOp("mul_256_256", OP_MUL, 17'd256, 17'd256, 17'h0, 1'b1, 21, 0, 1);
    runOp("mul_m256_256", OP_MUL, 17'h1FF00, 17'd256, 17'h10000, 1'b0, 21, 1, 1);
    runOp("mul_0_m5", OP_MUL, 17'd0, 17'h1FFFB, 17'h0, 1'b0, 21, 1, 1);
    runOp("mul_255_257", OP_MUL, 17'd255, 17'd257, 17'h0FFFF, 1'b0, 21, 1, 1);
    runOp("mul_m257_255", OP_MUL, 17'h1FEFF, 17'd255, 17'h10001, 1'b0, 21, 1, 1);
    runOp("mul_m1_m1", OP_MUL, 17'h1FFFF, 17'h1FFFF, 17'h1, 1'b0, 21, 1, 1);
    runOp("mul_min_1", OP_MUL, 17'h10000, 17'd1, 17'h10000, 1'b0, 21, 1, 1);
    runOp("mul_min_m1", OP_MUL, 17'h10000, 17'h1FFFF, 17'h0, 1'b1, 21, 0, 1);
    runOp("mul_ffff_3", OP_MUL, 17'h0FFFF, 17'd3, 17'h0, 1'b1, 21, 0, 1);
    runOp("mul_3_8000", OP_MUL, 17'd3, 17'h08000, 17'h0, 1'b1, 21, 0, 1);

    // A start raised mid-multiply must be dropped without disturbing the product.
    @(negedge clk);
    applyStimulus(OP_MUL, 17'd7, 17'h1FFFD);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 17'd1; b = 17'd1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("mul_ignore.latency", 32'(lat), 32'd21);
    checkOutput("mul_ignore.result", 32'(result), 32'h1FFEB);
    checkOutput("mul_ignore.ovf", 32'(ovf), 32'd0);

    runOp("b2b_add", OP_ADD, 17'd1000, 17'd2000, 17'h00BB8, 1'b0, 2, 1, 0);
    runOp("b2b_mul", OP_MUL, 17'd123, 17'h1FFD3, 17'h1EA61, 1'b0, 21, 1, 0);
    runOp("b2b_neg", OP_NEG, 17'd5, 17'd0, 17'h1FFFB, 1'b0, 2, 1, 0);

    // Reset in the middle of a multiply aborts it with no done pulse.
    @(negedge clk);
    applyStimulus(OP_MUL, 17'd100, 17'd100);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.result", 32'(result), 32'd0);
    checkOutput("abort.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    runOp("post_reset_add", OP_ADD, 17'd3, 17'd4, 17'd7, 1'b0, 2, 1, 0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
